game_score_tracker: RTL

Game-status stage directly downstream of the collision checker. Once per game frame it consumes the collision result and the current speed setting, and from them maintains the lives count, the invulnerability window, a BCD running score, a BCD high score and the game-over flag. It replaces fixed-delay waiting with a tick/busy/done handshake toward the top-level frame FSM. Its outputs feed the draw stage (score/lives digits) and the LED status bits.

---
 rtl/game_pkg.sv | 15 +
 rtl/bcd_digit_add.sv | 28 ++
 rtl/game_score_tracker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the game-status stage.
package game_pkg;
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        HIGH,
        DONE,
        OVER
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         LIVES_W = 3;
endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder: digit + addend + carry-in, producing a corrected digit and carry-out.
module bcd_digit_add
    import game_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic [BCD_W-1:0] i_addend,
    input  logic             i_carry,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_carry
);
    localparam logic [BCD_W:0] TEN = (BCD_W+1)'(10);

    logic [BCD_W:0] w_sum;
    logic [BCD_W:0] w_sum_adj;

    assign w_sum     = {1'b0, i_digit} + {1'b0, i_addend} + {{BCD_W{1'b0}}, i_carry};
    assign w_sum_adj = w_sum - TEN;

    always_comb begin
        if (w_sum >= TEN) begin
            o_digit = w_sum_adj[BCD_W-1:0];
            o_carry = 1'b1;
        end else begin
            o_digit = w_sum[BCD_W-1:0];
            o_carry = 1'b0;
        end
    end
endmodule

// File: rtl/game_score_tracker.sv
// Per-frame lives/immunity/score bookkeeping with a tick/busy/done handshake.
// The score is updated digit-serially through a single shared BCD digit adder.
module game_score_tracker
    import game_pkg::*;
#(
    parameter int SCORE_DIGITS  = 4,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_frame_tick,
    input  logic                          i_collision,
    input  logic [3:0]                    i_speed,
    input  logic                          i_restart,
    output logic [BCD_W*SCORE_DIGITS-1:0] o_score_bcd,
    output logic [BCD_W*SCORE_DIGITS-1:0] o_high_bcd,
    output logic [LIVES_W-1:0]            o_lives,
    output logic                          o_invulnerable,
    output logic                          o_game_over,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overrun
);
    localparam int                  SW       = BCD_W * SCORE_DIGITS;
    localparam int                  IDX_W    = $clog2(SCORE_DIGITS);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(SCORE_DIGITS - 1);
    localparam logic [LIVES_W-1:0]  LIVES_LD = LIVES_W'(LIVES_INIT);
    localparam logic [7:0]          INV_LD   = 8'(INVULN_FRAMES);
    localparam logic [SW-1:0]       SCORE_SAT = {SCORE_DIGITS{BCD_MAX}};

    state_t               r_state;
    logic [SW-1:0]        r_score;
    logic [SW-1:0]        r_high;
    logic [LIVES_W-1:0]   r_lives;
    logic [7:0]           r_inv;
    logic                 r_game_over;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;
    logic                 r_coll;
    logic [BCD_W-1:0]     r_ones;
    logic [BCD_W-1:0]     r_tens;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_carry;

    logic [BCD_W-1:0]     w_digit_in;
    logic [BCD_W-1:0]     w_addend;
    logic [BCD_W-1:0]     w_digit_out;
    logic                 w_carry_out;

    // Speed only contributes to the two lowest digits; higher digits just ripple the carry.
    assign w_digit_in = r_score[r_idx*BCD_W +: BCD_W];
    assign w_addend   = (r_idx == IDX_W'(0)) ? r_ones :
                        (r_idx == IDX_W'(1)) ? r_tens : '0;

    bcd_digit_add u_add (
        .i_digit  (w_digit_in),
        .i_addend (w_addend),
        .i_carry  (r_carry),
        .o_digit  (w_digit_out),
        .o_carry  (w_carry_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_score     <= '0;
            r_high      <= '0;
            r_lives     <= LIVES_LD;
            r_inv       <= '0;
            r_game_over <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_coll      <= 1'b0;
            r_ones      <= '0;
            r_tens      <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_frame_tick && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_restart) begin
                        r_score   <= '0;
                        r_lives   <= LIVES_LD;
                        r_inv     <= '0;
                        r_overrun <= 1'b0;
                    end else if (i_frame_tick) begin
                        r_coll <= i_collision;
                        if (i_speed >= 4'd10) begin
                            r_ones <= i_speed - 4'd10;
                            r_tens <= 4'd1;
                        end else begin
                            r_ones <= i_speed;
                            r_tens <= 4'd0;
                        end
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_idx   <= '0;
                    r_carry <= 1'b0;
                    r_state <= ADD;
                    if (r_inv != '0) begin
                        r_inv <= r_inv - 8'd1;
                    end else if (r_coll) begin
                        r_lives <= r_lives - LIVES_W'(1);
                        r_inv   <= INV_LD;
                        if (r_lives == LIVES_W'(1)) begin
                            r_game_over <= 1'b1;
                            r_state     <= HIGH;
                        end
                    end
                end
                ADD: begin
                    r_score[r_idx*BCD_W +: BCD_W] <= w_digit_out;
                    r_carry <= w_carry_out;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        if (w_carry_out) begin
                            r_score <= SCORE_SAT;
                        end
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (r_score > r_high) begin
                        r_high <= r_score;
                    end
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= r_game_over ? OVER : IDLE;
                end
                OVER: begin
                    if (i_restart) begin
                        r_score     <= '0;
                        r_lives     <= LIVES_LD;
                        r_inv       <= '0;
                        r_game_over <= 1'b0;
                        r_overrun   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_score_bcd    = r_score;
    assign o_high_bcd     = r_high;
    assign o_lives        = r_lives;
    assign o_invulnerable = (r_inv != '0);
    assign o_game_over    = r_game_over;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_overrun      = r_overrun;
endmodule
